cart_loader: RTL and testbench

- Sits between data_io (ioctl byte stream) and the sdram write port.
- Turns each ioctl_wr byte into a toggle-handshake SDRAM write, and throttles the host via ioctl_wait.
- Builds the cart address mask and detects the 512-byte copier header.
- Decodes the console type (SMS/GG) from ioctl_index for the system core and the sdram read-address logic.

---
 rtl/cart_loader_if.sv | 42 ++++
 rtl/cart_loader.sv | 211 +++++++++++++++++++++
 tb/tb_cart_loader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/cart_loader_if.sv
// ioctl byte stream plus SDRAM write port of cart_loader; "slave" is the loader, "master" is the data_io/sdram side.
// The checksum signal exists only when CART_LOADER_CHECKSUM_EN is defined.
interface cart_loader_if #(
    parameter int ADDR_W = 22
);
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic [7:0]        ioctl_index;
    logic              ioctl_wait;
    logic [ADDR_W-1:0] waddr;
    logic [7:0]        wdata;
    logic              we;
    logic              we_ack;
    logic [ADDR_W-1:0] cart_mask;
    logic [9:0]        rd_offset;
    logic              gg;
    logic              overflow;
    logic              load_done;
`ifdef CART_LOADER_CHECKSUM_EN
    logic [15:0]       checksum;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, we_ack,
        input  ioctl_wait, waddr, wdata, we, cart_mask, rd_offset, gg, overflow, load_done, checksum
    );
    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, we_ack,
        output ioctl_wait, waddr, wdata, we, cart_mask, rd_offset, gg, overflow, load_done, checksum
    );
`else
    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, we_ack,
        input  ioctl_wait, waddr, wdata, we, cart_mask, rd_offset, gg, overflow, load_done
    );
    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, we_ack,
        output ioctl_wait, waddr, wdata, we, cart_mask, rd_offset, gg, overflow, load_done
    );
`endif
endinterface

// File: rtl/cart_loader.sv
// cart_loader: ioctl bytes -> toggle-handshake SDRAM writes, cart mask, copier-header and GG detect; optional checksum via CART_LOADER_CHECKSUM_EN.
// Latency: we toggles 2 cycles after an accepted ioctl_wr. Backpressure: ioctl_wait high ISSUE..last ack, 1-entry skid, excess bytes dropped (overflow).
module cart_loader #(
    parameter int ADDR_W   = 22,
    parameter int HDR_SIZE = 512
) (
    input  logic         clk_sys,
    input  logic         reset,
    cart_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_ACK, FINISH} state_t;

    localparam logic [9:0] HDR_OFF = 10'(HDR_SIZE);
    localparam logic [9:0] HDR_LOW = 10'((HDR_SIZE - 1) % 1024);

    state_t            state_q, state_d;
    logic              dl_q;
    logic              skid_vld_q, skid_vld_d;
    logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;
    logic [7:0]        skid_data_q, skid_data_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              wait_q, wait_d;
    logic [ADDR_W-1:0] mask_q, mask_d;
    logic [9:0]        rd_off_q, rd_off_d;
    logic              gg_q, gg_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic              end_pend_q, end_pend_d;
    logic              got_q, got_d;
    logic [9:0]        last_lo_q, last_lo_d;
`ifdef CART_LOADER_CHECKSUM_EN
    logic [15:0]       sum_q, sum_d;
    logic [15:0]       hsum_q, hsum_d;
`endif

    logic rise, fall, busy, room, addr_ok, take;
    logic unused_idx;

    assign rise       = bus.ioctl_download & ~dl_q;
    assign fall       = ~bus.ioctl_download & dl_q;
    assign busy       = (state_q == ISSUE) || (state_q == WAIT_ACK);
    // The skid entry is consumed in ISSUE, so a byte arriving there still fits.
    assign room       = (state_q == LOAD) || (state_q == ISSUE) || (state_q == WAIT_ACK && !skid_vld_q);
    assign addr_ok    = (bus.ioctl_addr[24:ADDR_W] == '0);
    assign unused_idx = ^bus.ioctl_index[5:0];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= IDLE;
            dl_q        <= 1'b0;
            skid_vld_q  <= 1'b0;
            skid_addr_q <= '0;
            skid_data_q <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            wait_q      <= 1'b0;
            mask_q      <= '0;
            rd_off_q    <= '0;
            gg_q        <= 1'b0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            end_pend_q  <= 1'b0;
            got_q       <= 1'b0;
            last_lo_q   <= '0;
`ifdef CART_LOADER_CHECKSUM_EN
            sum_q       <= '0;
            hsum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            dl_q        <= bus.ioctl_download;
            skid_vld_q  <= skid_vld_d;
            skid_addr_q <= skid_addr_d;
            skid_data_q <= skid_data_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            wait_q      <= wait_d;
            mask_q      <= mask_d;
            rd_off_q    <= rd_off_d;
            gg_q        <= gg_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
            end_pend_q  <= end_pend_d;
            got_q       <= got_d;
            last_lo_q   <= last_lo_d;
`ifdef CART_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
            hsum_q      <= hsum_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        skid_vld_d  = skid_vld_q;
        skid_addr_d = skid_addr_q;
        skid_data_d = skid_data_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        wait_d      = wait_q;
        mask_d      = mask_q;
        rd_off_d    = rd_off_q;
        gg_d        = gg_q;
        ovf_d       = ovf_q;
        done_d      = 1'b0;
        end_pend_d  = end_pend_q;
        got_d       = got_q;
        last_lo_d   = last_lo_q;
        take        = 1'b0;
`ifdef CART_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
        hsum_d      = hsum_q;
`endif

        if (rise) begin
            mask_d     = '0;
            ovf_d      = 1'b0;
            rd_off_d   = '0;
            gg_d       = (bus.ioctl_index[7:6] == 2'd2);
            end_pend_d = 1'b0;
            got_d      = 1'b0;
`ifdef CART_LOADER_CHECKSUM_EN
            sum_d      = '0;
            hsum_d     = '0;
`endif
        end
        if (fall && busy) end_pend_d = 1'b1;

        if (state_q == ISSUE) begin
            waddr_d    = skid_addr_q;
            wdata_d    = skid_data_q;
            we_d       = ~we_q;
            skid_vld_d = 1'b0;
        end

        if (bus.ioctl_wr && (state_q == LOAD || busy)) begin
            if (!addr_ok || !room) begin
                ovf_d = 1'b1;
            end else begin
                take        = 1'b1;
                skid_vld_d  = 1'b1;
                skid_addr_d = bus.ioctl_addr[ADDR_W-1:0];
                skid_data_d = bus.ioctl_dout;
                mask_d      = mask_d | bus.ioctl_addr[ADDR_W-1:0];
                last_lo_d   = bus.ioctl_addr[9:0];
                got_d       = 1'b1;
`ifdef CART_LOADER_CHECKSUM_EN
                sum_d = sum_d + {8'd0, bus.ioctl_dout};
                if ({7'd0, bus.ioctl_addr} < 32'(HDR_SIZE)) hsum_d = hsum_d + {8'd0, bus.ioctl_dout};
`endif
            end
        end

        case (state_q)
            IDLE: ;
            LOAD: begin
                if (take) begin
                    wait_d  = 1'b1;
                    state_d = ISSUE;
                    if (fall) end_pend_d = 1'b1;
                end else if (fall) begin
                    state_d = FINISH;
                end
            end
            ISSUE: state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (bus.we_ack == we_q) begin
                    if (skid_vld_d) begin
                        state_d = ISSUE;
                    end else begin
                        wait_d  = 1'b0;
                        state_d = end_pend_d ? FINISH : LOAD;
                    end
                end
            end
            FINISH: begin
                if (!rise) begin
                    done_d     = 1'b1;
                    end_pend_d = 1'b0;
                    state_d    = IDLE;
                    rd_off_d   = (got_q && last_lo_q == HDR_LOW) ? HDR_OFF : 10'd0;
`ifdef CART_LOADER_CHECKSUM_EN
                    if (got_q && last_lo_q == HDR_LOW) sum_d = sum_q - hsum_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // A new download restarts immediately unless a handshake is in flight.
        if (rise && !busy) state_d = LOAD;
    end

    assign bus.ioctl_wait = wait_q;
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = wdata_q;
    assign bus.we         = we_q;
    assign bus.cart_mask  = mask_q;
    assign bus.rd_offset  = rd_off_q;
    assign bus.gg         = gg_q;
    assign bus.overflow   = ovf_q;
    assign bus.load_done  = done_q;
`ifdef CART_LOADER_CHECKSUM_EN
    assign bus.checksum   = sum_q;
`endif
endmodule

// File: tb/tb_cart_loader.sv
// Directed bench for cart_loader: single-byte vector table plus hand-written multi-cycle sequences.
module tb_cart_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cart_loader_if #(.ADDR_W(22)) bus();
    cart_loader #(.ADDR_W(22), .HDR_SIZE(512)) dut (.clk_sys(clk), .reset(reset), .bus(bus));

    int n_chk = 0;
    int n_err = 0;
    int ack_dly = 2;
    int tog = 0;
    int wait_rise = 0;
    int done_cnt = 0;
    logic [29:0] wq[$];

    typedef struct {
        logic [7:0]  idx;
        logic [24:0] addr;
        logic [7:0]  data;
        logic        exp_wr;
        logic [21:0] exp_mask;
        logic        exp_ovf;
        logic        exp_gg;
        logic [9:0]  exp_rd;
    } vec_t;
    vec_t vt[6];

    // SDRAM model and activity monitor, sampled 1 time unit after the active edge.
    initial begin
        logic we_prev, wait_prev, sd_busy;
        int sd_cnt;
        bus.we_ack = 1'b0;
        we_prev = 1'b0; wait_prev = 1'b0; sd_busy = 1'b0; sd_cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                bus.we_ack = 1'b0; sd_busy = 1'b0; we_prev = 1'b0; wait_prev = 1'b0;
            end else begin
                if (bus.we !== we_prev) begin tog++; wq.push_back({bus.waddr, bus.wdata}); end
                we_prev = bus.we;
                if (bus.ioctl_wait === 1'b1 && !wait_prev) wait_rise++;
                wait_prev = bus.ioctl_wait;
                if (bus.load_done === 1'b1) done_cnt++;
                if (!sd_busy && bus.we_ack !== bus.we) begin sd_busy = 1'b1; sd_cnt = ack_dly; end
                if (sd_busy) begin
                    if (sd_cnt == 0) begin bus.we_ack = bus.we; sd_busy = 1'b0; end
                    else sd_cnt--;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] get_wr(input int i);
        if (i < wq.size()) return {2'b00, wq[i]};
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] wexp(input logic [21:0] a, input logic [7:0] d);
        return {2'b00, a, d};
    endfunction

    task automatic clear_log();
        tog = 0; wait_rise = 0; done_cnt = 0; wq.delete();
    endtask

    task automatic start_dl(input logic [7:0] idx);
        bus.ioctl_index = idx;
        bus.ioctl_download = 1'b1;
        @(negedge clk);
        clear_log();
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        bus.ioctl_wr = 1'b1; bus.ioctl_addr = a; bus.ioctl_dout = d;
        @(negedge clk);
        bus.ioctl_wr = 1'b0;
    endtask

    task automatic wait_low(input int budget);
        int b = 0;
        while (bus.ioctl_wait === 1'b1 && b < budget) begin @(negedge clk); b++; end
        if (b >= budget) chk("wait_low_timeout", 32'(bus.ioctl_wait), 32'h0);
    endtask

    task automatic end_dl();
        bus.ioctl_download = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        vt[0] = '{8'h00, 25'h0000000, 8'hA5, 1'b1, 22'h000000, 1'b0, 1'b0, 10'd0};
        vt[1] = '{8'h80, 25'h0400000, 8'h5A, 1'b0, 22'h000000, 1'b1, 1'b1, 10'd0};
        vt[2] = '{8'h40, 25'h03FFFFF, 8'h3C, 1'b1, 22'h3FFFFF, 1'b0, 1'b0, 10'd0};
        vt[3] = '{8'hC0, 25'h00001FF, 8'h77, 1'b1, 22'h0001FF, 1'b0, 1'b0, 10'd512};
        vt[4] = '{8'h81, 25'h1000000, 8'h01, 1'b0, 22'h000000, 1'b1, 1'b1, 10'd0};
        vt[5] = '{8'h02, 25'h00005FF, 8'h99, 1'b1, 22'h0005FF, 1'b0, 1'b0, 10'd512};

        bus.ioctl_download = 1'b0; bus.ioctl_wr = 1'b0; bus.ioctl_addr = '0;
        bus.ioctl_dout = '0; bus.ioctl_index = '0;
        repeat (3) @(negedge clk);
        chk("rst_wait", 32'(bus.ioctl_wait), 32'h0);
        chk("rst_we", 32'(bus.we), 32'h0);
        chk("rst_waddr", 32'(bus.waddr), 32'h0);
        chk("rst_wdata", 32'(bus.wdata), 32'h0);
        chk("rst_mask", 32'(bus.cart_mask), 32'h0);
        chk("rst_rd", 32'(bus.rd_offset), 32'h0);
        chk("rst_gg", 32'(bus.gg), 32'h0);
        chk("rst_ovf", 32'(bus.overflow), 32'h0);
        chk("rst_done", 32'(bus.load_done), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        ack_dly = 2;
        for (int i = 0; i < 6; i++) begin
            start_dl(vt[i].idx);
            wr_byte(vt[i].addr, vt[i].data);
            wait_low(50);
            end_dl();
            chk($sformatf("v%0d_tog", i), 32'(tog), 32'(vt[i].exp_wr));
            if (vt[i].exp_wr) chk($sformatf("v%0d_wr", i), get_wr(0), wexp(vt[i].addr[21:0], vt[i].data));
            chk($sformatf("v%0d_mask", i), 32'(bus.cart_mask), 32'(vt[i].exp_mask));
            chk($sformatf("v%0d_ovf", i), 32'(bus.overflow), 32'(vt[i].exp_ovf));
            chk($sformatf("v%0d_gg", i), 32'(bus.gg), 32'(vt[i].exp_gg));
            chk($sformatf("v%0d_rd", i), 32'(bus.rd_offset), 32'(vt[i].exp_rd));
            chk($sformatf("v%0d_done", i), 32'(done_cnt), 32'd1);
        end

        // Four sequential bytes, ack 3 cycles after each toggle.
        ack_dly = 3;
        start_dl(8'h00);
        for (int i = 0; i < 4; i++) begin wr_byte(25'(i), 8'(8'h11 * (i + 1))); wait_low(50); end
        end_dl();
        chk("a_tog", 32'(tog), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("a_wr%0d", i), get_wr(i), wexp(22'(i), 8'(8'h11 * (i + 1))));
        chk("a_mask", 32'(bus.cart_mask), 32'h3);
        chk("a_rd", 32'(bus.rd_offset), 32'h0);
        chk("a_done", 32'(done_cnt), 32'd1);

        // Header detect: sparse address sweep ending at 0x81FF, then one ending at 0x7FFF.
        ack_dly = 0;
        start_dl(8'h00);
        for (int a = 0; a < 'h200; a++) begin wr_byte(25'(a), 8'(a)); wait_low(20); end
        for (int k = 9; k < 15; k++) begin wr_byte(25'(1 << k), 8'h00); wait_low(20); end
        for (int a = 'h8000; a < 'h8200; a++) begin wr_byte(25'(a), 8'(a)); wait_low(20); end
        end_dl();
        chk("b_tog", 32'(tog), 32'd1030);
        chk("b_mask", 32'(bus.cart_mask), 32'h00FFFF);
        chk("b_rd", 32'(bus.rd_offset), 32'd512);
        start_dl(8'h00);
        for (int a = 0; a < 'h200; a++) begin wr_byte(25'(a), 8'(a)); wait_low(20); end
        for (int k = 9; k < 15; k++) begin wr_byte(25'(1 << k), 8'h00); wait_low(20); end
        wr_byte(25'h7FFF, 8'hEE); wait_low(20);
        end_dl();
        chk("b2_mask", 32'(bus.cart_mask), 32'h007FFF);
        chk("b2_rd", 32'(bus.rd_offset), 32'd0);

        // Two writes 2 cycles apart under a slow ack: wait must stay high throughout.
        ack_dly = 10;
        start_dl(8'h00);
        wr_byte(25'h10, 8'hA1);
        @(negedge clk);
        wr_byte(25'h11, 8'hB2);
        wait_low(100);
        end_dl();
        chk("c_tog", 32'(tog), 32'd2);
        chk("c_wr0", get_wr(0), wexp(22'h10, 8'hA1));
        chk("c_wr1", get_wr(1), wexp(22'h11, 8'hB2));
        chk("c_wait_rise", 32'(wait_rise), 32'd1);
        chk("c_ovf", 32'(bus.overflow), 32'h0);

        // Three back-to-back writes: the third finds the skid full.
        start_dl(8'h00);
        bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h20; bus.ioctl_dout = 8'hD0;
        @(negedge clk); bus.ioctl_addr = 25'h21; bus.ioctl_dout = 8'hD1;
        @(negedge clk); bus.ioctl_addr = 25'h22; bus.ioctl_dout = 8'hD2;
        @(negedge clk); bus.ioctl_wr = 1'b0;
        wait_low(100);
        end_dl();
        chk("d_tog", 32'(tog), 32'd2);
        chk("d_wr0", get_wr(0), wexp(22'h20, 8'hD0));
        chk("d_wr1", get_wr(1), wexp(22'h21, 8'hD1));
        chk("d_ovf", 32'(bus.overflow), 32'h1);
        chk("d_mask", 32'(bus.cart_mask), 32'h21);

        // Reset while waiting for an ack.
        reset = 1'b1; @(negedge clk); @(negedge clk); reset = 1'b0;
        start_dl(8'h00);
        wr_byte(25'h5, 8'h55);
        @(negedge clk);
        chk("e_we_pre", 32'(bus.we), 32'h1);
        chk("e_state_pre", 32'(int'(dut.state_q)), 32'd3);
        reset = 1'b1; bus.ioctl_download = 1'b0;
        @(negedge clk);
        chk("e_wait", 32'(bus.ioctl_wait), 32'h0);
        chk("e_we", 32'(bus.we), 32'h0);
        chk("e_state", 32'(int'(dut.state_q)), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Fresh download after the reset.
        ack_dly = 2;
        start_dl(8'h80);
        wr_byte(25'h100, 8'hC3); wait_low(50);
        wr_byte(25'h200, 8'h3C); wait_low(50);
        end_dl();
        chk("f_tog", 32'(tog), 32'd2);
        chk("f_wr0", get_wr(0), wexp(22'h100, 8'hC3));
        chk("f_wr1", get_wr(1), wexp(22'h200, 8'h3C));
        chk("f_mask", 32'(bus.cart_mask), 32'h300);
        chk("f_gg", 32'(bus.gg), 32'h1);
        chk("f_ovf", 32'(bus.overflow), 32'h0);
        chk("f_done", 32'(done_cnt), 32'd1);

`ifdef CART_LOADER_CHECKSUM_EN
        start_dl(8'h00);
        wr_byte(25'h0, 8'hFF); wait_low(50);
        wr_byte(25'h1, 8'h01); wait_low(50);
        wr_byte(25'h2, 8'h80); wait_low(50);
        end_dl();
        chk("g_checksum", 32'(bus.checksum), 32'h0180);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
